// File: rtl/mem_access_unit_if.sv
// Word-wide data-memory bus between the MEM-stage access unit (master) and data memory (slave).
// Handshake: MEM_READ / MEM_WRITE act as the request valid and ~MEM_BUSYWAIT as ready. A transfer
// completes on a posedge where a strobe is high and MEM_BUSYWAIT is low. The master holds
// MEM_ADDRESS, MEM_WRITEDATA and MEM_BYTEEN stable until that edge. The master may withdraw a
// strobe without a transfer only when an access is aborted by timeout or by reset.
interface mem_access_unit_if;
    logic [31:0] MEM_ADDRESS;
    logic        MEM_READ;
    logic        MEM_WRITE;
    logic [31:0] MEM_WRITEDATA;
    logic [3:0]  MEM_BYTEEN;
    logic [31:0] MEM_READDATA;
    logic        MEM_BUSYWAIT;

    modport master (
        output MEM_ADDRESS,
        output MEM_READ,
        output MEM_WRITE,
        output MEM_WRITEDATA,
        output MEM_BYTEEN,
        input  MEM_READDATA,
        input  MEM_BUSYWAIT
    );

    modport slave (
        input  MEM_ADDRESS,
        input  MEM_READ,
        input  MEM_WRITE,
        input  MEM_WRITEDATA,
        input  MEM_BYTEEN,
        output MEM_READDATA,
        output MEM_BUSYWAIT
    );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access controller: decodes the EX/MEM access code, drives the word bus,
// stalls the pipeline while an access is in flight and returns extended load data.
module mem_access_unit #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int TMO_W          = 7
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [3:0]        IN_READ_WRITE,
    input  logic [31:0]       IN_ADDRESS,
    input  logic [31:0]       IN_DATA2,
    output logic [31:0]       OUT_LOAD_DATA,
    output logic              BUSYWAIT,
    output logic              MISALIGNED,
    output logic              MEM_ERROR,
    output logic [1:0]        DBG_STATE,
    mem_access_unit_if.master mem
);

    localparam logic [3:0] RW_LB  = 4'b1000;
    localparam logic [3:0] RW_LH  = 4'b1001;
    localparam logic [3:0] RW_LW  = 4'b1010;
    localparam logic [3:0] RW_LBU = 4'b1100;
    localparam logic [3:0] RW_LHU = 4'b1101;
    localparam logic [3:0] RW_SB  = 4'b0101;
    localparam logic [3:0] RW_SH  = 4'b0110;
    localparam logic [3:0] RW_SW  = 4'b0111;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [TMO_W-1:0]   tmo_q;
    logic [TMO_W-1:0]   tmo_inc;

    logic [31:0]        addr_q;
    logic [1:0]         lane_q;
    logic [3:0]         code_q;
    logic               rd_q;
    logic               wr_q;
    logic [31:0]        wdata_q;
    logic [3:0]         byteen_q;
    logic [31:0]        load_q;
    logic               misaligned_q;
    logic               mem_error_q;

    logic               op_load;
    logic               op_store;
    logic [1:0]         op_size;
    logic               op_aligned;
    logic [31:0]        op_wdata;
    logic [3:0]         op_byteen;

    logic               start;
    logic               complete;
    logic               abort;
    logic               mis_d;

    logic [7:0]         rd_byte;
    logic [15:0]        rd_half;
    logic [31:0]        load_ext;

    // Access-code decode; anything not listed is a pipeline bubble.
    always_comb begin
        op_load  = 1'b0;
        op_store = 1'b0;
        op_size  = SZ_B;
        case (IN_READ_WRITE)
            RW_LB:   begin op_load  = 1'b1; op_size = SZ_B; end
            RW_LBU:  begin op_load  = 1'b1; op_size = SZ_B; end
            RW_LH:   begin op_load  = 1'b1; op_size = SZ_H; end
            RW_LHU:  begin op_load  = 1'b1; op_size = SZ_H; end
            RW_LW:   begin op_load  = 1'b1; op_size = SZ_W; end
            RW_SB:   begin op_store = 1'b1; op_size = SZ_B; end
            RW_SH:   begin op_store = 1'b1; op_size = SZ_H; end
            RW_SW:   begin op_store = 1'b1; op_size = SZ_W; end
            default: begin op_load  = 1'b0; op_store = 1'b0; end
        endcase
    end

    always_comb begin
        op_aligned = 1'b1;
        if (op_size == SZ_H) begin
            op_aligned = ~IN_ADDRESS[0];
        end else if (op_size == SZ_W) begin
            op_aligned = (IN_ADDRESS[1:0] == 2'b00);
        end
    end

    // Store data is replicated across lanes so the byte enables alone pick the target bytes.
    always_comb begin
        op_wdata  = 32'h0;
        op_byteen = 4'b0000;
        case (IN_READ_WRITE)
            RW_SB: begin
                op_wdata  = {4{IN_DATA2[7:0]}};
                op_byteen = 4'b0001 << IN_ADDRESS[1:0];
            end
            RW_SH: begin
                op_wdata  = {2{IN_DATA2[15:0]}};
                op_byteen = 4'b0011 << IN_ADDRESS[1:0];
            end
            RW_SW: begin
                op_wdata  = IN_DATA2;
                op_byteen = 4'b1111;
            end
            default: begin
                op_wdata  = 32'h0;
                op_byteen = 4'b0000;
            end
        endcase
    end

    always_comb begin
        rd_byte = mem.MEM_READDATA[7:0];
        case (lane_q)
            2'd0: rd_byte = mem.MEM_READDATA[7:0];
            2'd1: rd_byte = mem.MEM_READDATA[15:8];
            2'd2: rd_byte = mem.MEM_READDATA[23:16];
            2'd3: rd_byte = mem.MEM_READDATA[31:24];
            default: rd_byte = mem.MEM_READDATA[7:0];
        endcase
        rd_half = lane_q[1] ? mem.MEM_READDATA[31:16] : mem.MEM_READDATA[15:0];
    end

    always_comb begin
        load_ext = 32'h0;
        case (code_q)
            RW_LB:   load_ext = {{24{rd_byte[7]}}, rd_byte};
            RW_LBU:  load_ext = {24'h0, rd_byte};
            RW_LH:   load_ext = {{16{rd_half[15]}}, rd_half};
            RW_LHU:  load_ext = {16'h0, rd_half};
            RW_LW:   load_ext = mem.MEM_READDATA;
            default: load_ext = 32'h0;
        endcase
    end

    // BUSYWAIT is combinational in IDLE so the edge that sees a new op already stalls the pipe.
    always_comb begin
        state_d  = state_q;
        BUSYWAIT = 1'b0;
        start    = 1'b0;
        complete = 1'b0;
        abort    = 1'b0;
        mis_d    = 1'b0;
        tmo_inc  = tmo_q + 1'b1;
        case (state_q)
            S_IDLE: begin
                if ((op_load || op_store) && op_aligned) begin
                    BUSYWAIT = 1'b1;
                    start    = 1'b1;
                    state_d  = S_ACCESS;
                end else if (op_load || op_store) begin
                    mis_d    = 1'b1;
                end
            end
            S_ACCESS: begin
                BUSYWAIT = 1'b1;
                if (!mem.MEM_BUSYWAIT) begin
                    complete = 1'b1;
                    state_d  = S_DONE;
                end else if (tmo_inc == TMO_W'(TIMEOUT_CYCLES)) begin
                    abort    = 1'b1;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (!RESET) begin
            BUSYWAIT = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q      <= S_IDLE;
            tmo_q        <= '0;
            addr_q       <= 32'h0;
            lane_q       <= 2'b00;
            code_q       <= 4'b0000;
            rd_q         <= 1'b0;
            wr_q         <= 1'b0;
            wdata_q      <= 32'h0;
            byteen_q     <= 4'b0000;
            load_q       <= 32'h0;
            misaligned_q <= 1'b0;
            mem_error_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            misaligned_q <= mis_d;
            mem_error_q  <= abort;

            if (start) begin
                addr_q   <= {IN_ADDRESS[31:2], 2'b00};
                lane_q   <= IN_ADDRESS[1:0];
                code_q   <= IN_READ_WRITE;
                rd_q     <= op_load;
                wr_q     <= op_store;
                wdata_q  <= op_wdata;
                byteen_q <= op_byteen;
            end

            if (state_q == S_DONE) begin
                tmo_q <= '0;
            end else if (state_q == S_ACCESS && mem.MEM_BUSYWAIT) begin
                tmo_q <= tmo_inc;
            end

            // Load result is sticky: only a completed load or an abort changes it.
            if (complete && rd_q) begin
                load_q <= load_ext;
            end else if (abort) begin
                load_q <= 32'h0;
            end
        end
    end

    assign mem.MEM_ADDRESS   = addr_q;
    assign mem.MEM_READ      = (state_q == S_ACCESS) && rd_q;
    assign mem.MEM_WRITE     = (state_q == S_ACCESS) && wr_q;
    assign mem.MEM_WRITEDATA = wdata_q;
    assign mem.MEM_BYTEEN    = byteen_q;

    assign OUT_LOAD_DATA = load_q;
    assign MISALIGNED    = misaligned_q;
    assign MEM_ERROR     = mem_error_q;
    assign DBG_STATE     = state_q;

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage data-memory access controller, directly downstream of the EX/MEM pipeline register.
- Consumes the registered ALU result (address), DATA2 (store data) and the 4-bit READ_WRITE code.
- Drives a word-wide data-memory handshake and returns sign- or zero-extended load data to the MEM/WB path.
- Asserts BUSYWAIT to freeze all pipeline registers while an access is in flight.

Parameters:
- TIMEOUT_CYCLES, 64: max cycles spent in ACCESS before the access is aborted with MEM_ERROR.
- TMO_W, 7: width of the timeout counter; must satisfy 2^TMO_W > TIMEOUT_CYCLES.

Ports:
- CLK  in  1  clock; all state changes on posedge.
- RESET  in  1  asynchronous, active-low reset (0 = reset asserted).
- IN_READ_WRITE  in  4  access code from the EX/MEM register.
- IN_ADDRESS  in  32  byte address (EX/MEM ALU result).
- IN_DATA2  in  32  store data (EX/MEM DATA2).
- OUT_LOAD_DATA  out  32  extended load result.
- BUSYWAIT  out  1  pipeline stall request.
- MISALIGNED  out  1  one-cycle pulse on a misaligned access.
- MEM_ERROR  out  1  one-cycle pulse on a timeout abort.
- MEM_ADDRESS  out  32  word address to data memory; bits [1:0] always 0.
- MEM_READ  out  1  memory read strobe.
- MEM_WRITE  out  1  memory write strobe.
- MEM_WRITEDATA  out  32  lane-aligned store data.
- MEM_BYTEEN  out  4  byte-lane enables for writes.
- MEM_READDATA  in  32  word returned by memory.
- MEM_BUSYWAIT  in  1  memory not ready.

Behaviour:
- Access codes:
  - Loads: 1000 LB, 1001 LH, 1010 LW, 1100 LBU, 1101 LHU.
  - Stores: 0101 SB, 0110 SH, 0111 SW.
  - Every other code (including 0000) means no access.
- Alignment: halfword ops need ADDRESS[0]=0; word ops need ADDRESS[1:0]=00. A misaligned op never reaches memory.
- Reset (RESET=0, asynchronous):
  - state=IDLE, timeout counter=0, OUT_LOAD_DATA=0.
  - MISALIGNED, MEM_ERROR, MEM_READ, MEM_WRITE=0; MEM_BYTEEN=0.
  - BUSYWAIT=0, MEM_ADDRESS=0, MEM_WRITEDATA=0.
  - Reset mid-access drops the strobes immediately and returns to IDLE; the access is lost.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - Valid aligned op: BUSYWAIT=1 combinationally, so the current edge stalls; next state ACCESS; latch address, code, lane data and byte enables.
  - Valid misaligned op: MISALIGNED=1 for the following cycle; stay IDLE; BUSYWAIT=0.
  - No access: stay IDLE, BUSYWAIT=0.
- ACCESS:
  - BUSYWAIT=1. MEM_READ or MEM_WRITE held high with stable MEM_ADDRESS, MEM_WRITEDATA and MEM_BYTEEN.
  - Counter increments each cycle MEM_BUSYWAIT=1.
  - Posedge with MEM_BUSYWAIT=0: capture the extended load data into OUT_LOAD_DATA (loads only); go to DONE.
  - Counter reaching TIMEOUT_CYCLES: drop strobes, pulse MEM_ERROR, OUT_LOAD_DATA=0, go to DONE.
- DONE:
  - BUSYWAIT=0 and strobes low, so the pipeline advances on this edge.
  - Counter cleared; next state IDLE unconditionally. The same op is therefore never re-issued.
- Latency: minimum 2 stall cycles per access (IDLE detect + one ACCESS cycle); each MEM_BUSYWAIT cycle adds one.
- Stores:
  - SB: data = {4{DATA2[7:0]}}, BYTEEN = 0001 << ADDRESS[1:0].
  - SH: data = {2{DATA2[15:0]}}, BYTEEN = 0011 << ADDRESS[1:0].
  - SW: data = DATA2, BYTEEN = 1111.
  - BYTEEN = 0000 on reads.
- Loads:
  - Select the byte or half at ADDRESS[1:0] from MEM_READDATA.
  - LB and LH sign-extend; LBU and LHU zero-extend; LW passes the word unchanged.
- OUT_LOAD_DATA holds its value until the next load completes; stores do not change it.

Test Plan:
- RESET=0 asserted mid-ACCESS with MEM_BUSYWAIT=1: all outputs 0 immediately, state IDLE; after release, with no access, BUSYWAIT stays 0.
- LB at 0x1003 with MEM_READDATA=0x80FF_1234, MEM_BUSYWAIT=0: MEM_ADDRESS=0x1000, BUSYWAIT high exactly 2 cycles, OUT_LOAD_DATA=0xFFFF_FF80. Same access with LBU gives 0x0000_0080.
- SH at 0x2002 with DATA2=0xDEAD_BEEF and MEM_BUSYWAIT high 3 cycles: MEM_WRITE high 4 cycles, MEM_WRITEDATA=0xBEEF_BEEF, MEM_BYTEEN=1100, BUSYWAIT high 5 cycles, OUT_LOAD_DATA unchanged.
- LW at 0x3001: no MEM_READ, MISALIGNED pulse of 1 cycle, BUSYWAIT=0.
- MEM_BUSYWAIT stuck high with TIMEOUT_CYCLES=4: MEM_ERROR pulses after 4 ACCESS cycles, strobes drop, DONE then IDLE, OUT_LOAD_DATA=0.
- Back-to-back SW 0x10 then LW 0x10 with zero-wait memory: two distinct accesses, each 2 stall cycles, load returns the stored word, no duplicate write.
